// File: rtl/intersection_scheduler.sv
// Four-phase traffic signal scheduler: ALLRED -> GREEN -> YELLOW with demand-driven phase selection.
// Optional emergency preemption is compiled in only when EMERGENCY_PREEMPT_EN is defined.
module intersection_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 15,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       emg_req,
  input  logic [1:0] emg_dir,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic       all_red,
  output logic       emg_active
);

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] pending;
  logic [1:0] ptr;
  logic [1:0] cur;

  function automatic logic [3:0] phase_mask(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  // True once the dwell counter covers `limit` cycles in the current state.
  function automatic logic reached(input logic [7:0] c, input int limit);
    return ({1'b0, c} + 9'd1) >= 9'(limit);
  endfunction

  // Cyclic priority search starting at `start`; returns {found, phase}.
  function automatic logic [2:0] first_pending(input logic [3:0] p, input logic [1:0] start);
    logic [2:0] hit;
    logic [1:0] idx;
    hit = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (p[idx]) hit = {1'b1, idx};
    end
    return hit;
  endfunction

  logic       emg;
  logic [1:0] edir;

`ifdef EMERGENCY_PREEMPT_EN
  assign emg  = emg_req;
  assign edir = emg_dir;
`else
  logic unused_emg;
  assign emg        = 1'b0;
  assign edir       = 2'd0;
  assign unused_emg = ^{emg_req, emg_dir};
`endif

  logic [2:0] search;
  logic       grant_vld;
  logic [1:0] grant_ph;
  logic       others_pend;
  logic       ext_ok;
  logic       go_yellow;
  logic [7:0] cnt_inc;

  assign search      = first_pending(pending, ptr);
  assign grant_vld   = emg | search[2];
  assign grant_ph    = emg ? edir : search[1:0];
  assign others_pend = |(pending & ~phase_mask(cur));
  assign ext_ok      = ~req[cur] | reached(cnt, MAX_GREEN);
  assign cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Preemption overrides the minimum-green rule; otherwise leave only when another phase waits.
  assign go_yellow = emg ? (cur != edir)
                         : (reached(cnt, MIN_GREEN) && others_pend && ext_ok);

  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= ALLRED;
      cnt        <= 8'd0;
      pending    <= 4'd0;
      ptr        <= 2'd0;
      cur        <= 2'd0;
      green      <= 4'd0;
      yellow     <= 4'd0;
      all_red    <= 1'b1;
      emg_active <= 1'b0;
    end else begin
      cnt     <= cnt_inc;
      pending <= pending | req;
      case (state)
        ALLRED: begin
          if (reached(cnt, ALLRED_T) && grant_vld) begin
            state      <= GREEN;
            cnt        <= 8'd0;
            cur        <= grant_ph;
            pending    <= (pending | req) & ~phase_mask(grant_ph);
            green      <= phase_mask(grant_ph);
            all_red    <= 1'b0;
            emg_active <= emg;
          end
        end
        GREEN: begin
          if (go_yellow) begin
            state      <= YELLOW;
            cnt        <= 8'd0;
            green      <= 4'd0;
            yellow     <= phase_mask(cur);
            emg_active <= 1'b0;
          end else begin
            emg_active <= emg;
          end
        end
        YELLOW: begin
          if (reached(cnt, YELLOW_T)) begin
            state   <= ALLRED;
            cnt     <= 8'd0;
            ptr     <= cur + 2'd1;
            yellow  <= 4'd0;
            all_red <= 1'b1;
          end
        end
        default: begin
          state      <= ALLRED;
          cnt        <= 8'd0;
          green      <= 4'd0;
          yellow     <= 4'd0;
          all_red    <= 1'b1;
          emg_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed vector tables, hand sequences and a randomized
// run against a behavioural model of the phase rules.
module tb_intersection_scheduler;

  localparam int MIN_GREEN = 5;
  localparam int MAX_GREEN = 15;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 1;
`ifdef EMERGENCY_PREEMPT_EN
  localparam bit EMG = 1'b1;
`else
  localparam bit EMG = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'd0;
  logic       emg_req = 1'b0;
  logic [1:0] emg_dir = 2'd0;
  logic [3:0] green;
  logic [3:0] yellow;
  logic       all_red;
  logic       emg_active;

  intersection_scheduler #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
  ) dut (
    .Clk(Clk), .reset(reset), .req(req), .emg_req(emg_req), .emg_dir(emg_dir),
    .green(green), .yellow(yellow), .all_red(all_red), .emg_active(emg_active)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] req;
    logic       er;
    logic [1:0] ed;
    logic       rst;
    logic [3:0] eg;
    logic [3:0] ey;
    logic       ear;
    logic       eea;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  // Behavioural model: mode 0 = all red, 1 = green, 2 = yellow.
  int         m_mode, m_cnt, m_ptr, m_cur;
  logic [3:0] m_pend;
  bit         m_ea;

  bit         seen_y = 1'b0;
  int         ar_run = 0;
  logic [3:0] prev_g = 4'd0;

  function automatic vec_t mk(input logic [3:0] r, input logic er, input logic [1:0] ed,
                              input logic rst, input logic [3:0] eg, input logic [3:0] ey,
                              input logic ear, input logic eea);
    vec_t v;
    v.req = r; v.er = er; v.ed = ed; v.rst = rst;
    v.eg = eg; v.ey = ey; v.ear = ear; v.eea = eea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_ptr = 0; m_cur = 0; m_pend = 4'd0; m_ea = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic er, input logic [1:0] ed);
    int nmode, ncnt, nptr, ncur, g;
    logic [3:0] npend;
    bit nea, em, others;
    em    = EMG && er;
    nmode = m_mode;
    ncnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
    nptr  = m_ptr;
    ncur  = m_cur;
    npend = m_pend | r;
    nea   = m_ea;
    if (m_mode == 0) begin
      if (m_cnt >= ALLRED_T - 1) begin
        g = -1;
        if (em) g = int'(ed);
        else
          for (int k = 0; k < 4; k++)
            if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        if (g >= 0) begin
          nmode = 1; ncur = g; ncnt = 0; npend[g] = 1'b0; nea = em;
        end
      end
    end else if (m_mode == 1) begin
      others = (m_pend & ~(4'b0001 << m_cur)) != 4'd0;
      if (em && int'(ed) != m_cur) begin
        nmode = 2; ncnt = 0; nea = 1'b0;
      end else if (em) begin
        nea = 1'b1;
      end else begin
        nea = 1'b0;
        if (m_cnt >= MIN_GREEN - 1 && others && (!r[m_cur] || m_cnt >= MAX_GREEN - 1)) begin
          nmode = 2; ncnt = 0;
        end
      end
    end else begin
      if (m_cnt >= YELLOW_T - 1) begin
        nmode = 0; ncnt = 0; nptr = (m_cur + 1) % 4;
      end
    end
    m_mode = nmode; m_cnt = ncnt; m_ptr = nptr; m_cur = ncur; m_pend = npend; m_ea = nea;
  endtask

  task automatic tick(input logic [3:0] r, input logic er, input logic [1:0] ed, input logic rst);
    logic [3:0] mg, my;
    int lit;
    req = r; emg_req = er; emg_dir = ed; reset = rst;
    if (rst) model_reset();
    else model_step(r, er, ed);
    @(posedge Clk);
    #1;
    mg = (m_mode == 1) ? (4'b0001 << m_cur) : 4'b0000;
    my = (m_mode == 2) ? (4'b0001 << m_cur) : 4'b0000;
    chk("model", {22'd0, green, yellow, all_red, emg_active},
        {22'd0, mg, my, (m_mode == 0), m_ea});
    lit = $countones(green) + $countones(yellow) + int'(all_red);
    chk("exclusive", lit, 1);
    if (yellow != 4'd0) begin
      seen_y = 1'b1;
      ar_run = 0;
    end else if (all_red) begin
      ar_run++;
    end
    if (green != 4'd0 && prev_g == 4'd0 && seen_y) chk("allred_gap", (ar_run >= ALLRED_T), 1);
    prev_g = green;
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      tick(tbl[i].req, tbl[i].er, tbl[i].ed, tbl[i].rst);
      chk($sformatf("%s[%0d]", tag, i), {22'd0, green, yellow, all_red, emg_active},
          {22'd0, tbl[i].eg, tbl[i].ey, tbl[i].ear, tbl[i].eea});
    end
    tbl.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] grants[$];
    logic [3:0] pg;
    logic [3:0] rr;
    logic [1:0] ed_r;
    bit saw2, er_r, rs;
    model_reset();

    // Reset, single request on phase 2, then a short green and handover to phase 0.
    tbl.push_back(mk(4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 0, 0, 4'b0100, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 0, 0));
    run_tbl("basic");

    // Held request on phase 2 extends green to the maximum.
    tick(4'b0000, 0, 0, 1);
    tick(4'b0100, 0, 0, 0);
    tick(4'b0110, 0, 0, 0);
    n = 0;
    while (green == 4'b0100 && n < 100) begin
      n++;
      tick(4'b0100, 0, 0, 0);
    end
    chk("max_green_len", n, MAX_GREEN);
    chk("max_green_then_yellow", yellow, 4'b0100);

    // Latched pending 1011 from pointer 0 is served 0, 1, 3.
    tick(4'b0000, 0, 0, 1);
    tick(4'b1011, 0, 0, 0);
    pg = green;
    saw2 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick(4'b0000, 0, 0, 0);
      if (green != 4'd0 && green != pg) grants.push_back(green);
      if (green[2]) saw2 = 1'b1;
      pg = green;
    end
    chk("order_len", grants.size(), 3);
    chk("order0", (grants.size() > 0) ? grants[0] : 4'hF, 4'b0001);
    chk("order1", (grants.size() > 1) ? grants[1] : 4'hF, 4'b0010);
    chk("order2", (grants.size() > 2) ? grants[2] : 4'hF, 4'b1000);
    chk("phase2_never", saw2, 0);

    // Reset on the second yellow cycle of phase 1 also drops the pending phase 0 request.
    tick(4'b0000, 0, 0, 1);
    tick(4'b0010, 0, 0, 0);
    tick(4'b0001, 0, 0, 0);
    n = 0;
    while (yellow != 4'b0010 && n < 50) begin
      tick(4'b0000, 0, 0, 0);
      n++;
    end
    chk("yellow1_reached", yellow, 4'b0010);
    tick(4'b0000, 0, 0, 0);
    tick(4'b0000, 0, 0, 1);
    chk("rst_mid_yellow", {green, yellow, all_red, emg_active}, {4'b0000, 4'b0000, 1'b1, 1'b0});
    for (int i = 0; i < 6; i++) tick(4'b0000, 0, 0, 0);
    chk("pending_cleared", {green, all_red}, {4'b0000, 1'b1});

    // Emergency request toward phase 3 while phase 0 is one cycle into green.
    tick(4'b0000, 0, 0, 1);
    tick(4'b0001, 0, 0, 0);
    tick(4'b0000, 0, 0, 0);
    tick(4'b0000, 0, 0, 0);
    chk("pre_emg_green", green, 4'b0001);
`ifdef EMERGENCY_PREEMPT_EN
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0000, 1, 3, 0, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 3, 0, 4'b0000, 4'b0000, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0000, 1, 3, 0, 4'b1000, 4'b0000, 0, 1));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 0, 3, 0, 4'b1000, 4'b0000, 0, 0));
`else
    for (int i = 0; i < 7; i++) tbl.push_back(mk(4'b0000, 1, 3, 0, 4'b0001, 4'b0000, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(4'b0000, 0, 3, 0, 4'b0001, 4'b0000, 0, 0));
`endif
    run_tbl("emg");

    // Randomized traffic with occasional emergencies and resets.
    tick(4'b0000, 0, 0, 1);
    er_r = 1'b0;
    ed_r = 2'd0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++) rr[b] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) er_r = ~er_r;
      if ($urandom_range(0, 59) == 0) ed_r = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 499) == 0);
      tick(rr, er_r, ed_r, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 SHALL have parameter MIN_GREEN, default 5, minimum green cycles per phase (range 1..255).
REQ-002 SHALL have parameter MAX_GREEN, default 15, green cycles after which an extended phase ends (MIN_GREEN..255).
REQ-003 SHALL have parameter YELLOW_T, default 3, yellow cycles (1..255).
REQ-004 SHALL have parameter ALLRED_T, default 1, all-red clearance cycles (1..255).
REQ-005 SHALL have port Clk  input  1  sole clock; all state changes on posedge Clk.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req  input  4  per-phase vehicle sensor; bit i is approach/phase i.
REQ-008 SHALL have port emg_req  input  1  emergency preemption request, level-sensitive.
REQ-009 SHALL have port emg_dir  input  2  phase to be preempted to green.
REQ-010 SHALL have port green  output  4  one-hot green per phase, all-zero otherwise.
REQ-011 SHALL have port yellow  output  4  one-hot yellow per phase, all-zero otherwise.
REQ-012 SHALL have port all_red  output  1  high in ALLRED state.
REQ-013 SHALL have port emg_active  output  1  high while the current green was granted by preemption.

Function
REQ-014 SHALL implement states ALLRED, GREEN, YELLOW; 8-bit dwell counter cnt cleared on every state entry, saturating at 255.
REQ-015 SHALL keep pending[3:0]: bit i set on any cycle req[i]=1; cleared on the cycle phase i is granted green, with clear winning over a same-cycle set.
REQ-016 SHALL, in ALLRED with cnt>=ALLRED_T-1, grant: emg_dir if preemption active, else first pending bit searching cyclically from ptr; if neither, remain ALLRED.
REQ-017 SHALL, in GREEN of phase cur, go to YELLOW when cnt>=MIN_GREEN-1, some pending bit other than cur is set, and (req[cur]=0 or cnt>=MAX_GREEN-1).
REQ-018 SHALL rest in GREEN indefinitely when no other phase is pending.
REQ-019 SHALL go from YELLOW to ALLRED when cnt>=YELLOW_T-1, setting ptr=cur+1 mod 4.
REQ-020 SHALL register outputs so they are valid the cycle after the state register updates; green/yellow/all_red are mutually exclusive at all times.
REQ-021 SHALL never assert green on two phases, nor green on any phase without at least ALLRED_T all-red cycles since the previous yellow.

Reset
REQ-022 SHALL, with reset high at posedge Clk, force state=ALLRED, cnt=0, pending=0, ptr=0, cur=0, green=0, yellow=0, all_red=1, emg_active=0; reset overrides all inputs, including mid-GREEN/YELLOW.

Configuration
REQ-023 SHALL compile preemption only when macro EMERGENCY_PREEMPT_EN is defined.
REQ-024 SHALL, with EMERGENCY_PREEMPT_EN, treat emg_req=1 as: GREEN of cur!=emg_dir -> YELLOW next cycle ignoring MIN_GREEN; GREEN of emg_dir -> hold green, emg_active=1; YELLOW/ALLRED complete normally then grant emg_dir.
REQ-025 SHALL, with EMERGENCY_PREEMPT_EN, hold an emergency green while emg_req=1 and emg_dir unchanged; on emg_req falling, resume REQ-017 rules with cnt continuing.
REQ-026 SHALL, without EMERGENCY_PREEMPT_EN, ignore emg_req and emg_dir and tie emg_active to 0.

Verification
REQ-027 Reset, then req=4'b0100 for 1 cycle -> all_red for 1 cycle, then green=4'b0100 held with no further requests.
REQ-028 Green on phase 2, req[2]=0, req[0] pulsed -> green[2] lasts exactly 5 cycles, yellow[2] 3 cycles, all_red 1 cycle, then green=4'b0001.
REQ-029 Green on phase 2 with req[2] held high, req[1] pending -> green[2] lasts exactly 15 cycles before yellow[2].
REQ-030 From ALLRED with ptr=0, pending=4'b1011 latched, no new requests -> grant order phase 0, 1, 3; phase 2 never green.
REQ-031 EMERGENCY_PREEMPT_EN defined, green[0] at cnt=1, emg_req=1, emg_dir=3 -> yellow[0] next cycle for 3 cycles, all_red 1 cycle, green=4'b1000 with emg_active=1 until emg_req drops.
REQ-032 Reset asserted on cycle 2 of yellow[1] -> next cycle all_red=1, green=yellow=0, pending=0; without EMERGENCY_PREEMPT_EN, repeating REQ-031 stimulus leaves green[0] unaffected.
